// File: rtl/ascon_pkg.sv
// Shared types and defaults for the Ascon stream front-end.
// Holds the FSM state encoding, default field widths and beat-counter sizing.
// Pure declarations; no logic, no timing.
package ascon_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  localparam int unsigned K_DEF = 128;
  localparam int unsigned N_DEF = 128;
  localparam int unsigned L_DEF = 32;
  localparam int unsigned Y_DEF = 32;
  localparam int unsigned T_DEF = 128;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count beats 0..beats-1 (at least one bit).
  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ascon_lane_shreg.sv
// MSB-first lane shift register: shifts lane in at the LSBs while beat < LF/W.
// Latency: one cycle from enabled beat to parallel output.
// No backpressure; freezes once full until clear or reset.
module ascon_lane_shreg #(
  parameter int unsigned LF = 32,
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] beat,
  input  logic [W-1:0]  lane,
  output logic [LF-1:0] q
);

  localparam int unsigned LIM_I = LF / W;
  localparam logic [CW:0] LIM   = LIM_I[CW:0];

  // Shift while the field still has room; first beat ends up at the MSBs.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && ({1'b0, beat} < LIM)) begin
      q <= (q << W) | LF'(lane);
    end
  end

endmodule

// File: rtl/ascon_stream_io.sv
// Lane-wide stream front-end for the Ascon AEAD core (decrypt option: ASCON_DECRYPT_EN).
// Latency: core_start the cycle after the last input beat; out_valid the cycle after core_done.
// Backpressure: in_ready depends on state only; output beats hold stable while out_ready=0.
module ascon_stream_io
  import ascon_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned N = N_DEF,
  parameter int unsigned L = L_DEF,
  parameter int unsigned Y = Y_DEF,
  parameter int unsigned T = T_DEF,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
`ifdef ASCON_DECRYPT_EN
  input  logic         mode_i,
  input  logic [W-1:0] in_tag,
  output logic         mode_o,
  output logic         tag_ok,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_key,
  input  logic [W-1:0] in_nonce,
  input  logic [W-1:0] in_ad,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [W-1:0] out_tag,
  output logic         out_last,
  output logic [K-1:0] key_o,
  output logic [N-1:0] nonce_o,
  output logic [L-1:0] ad_o,
  output logic [Y-1:0] data_o,
  output logic         core_start,
  input  logic         core_done,
  input  logic [Y-1:0] core_data_i,
  input  logic [T-1:0] core_tag_i
);

  localparam int unsigned BI     = max2(max2(K, N), max2(L, Y)) / W;
  localparam int unsigned BO     = max2(Y, T) / W;
  localparam int unsigned CW     = beat_cnt_w(max2(BI, BO));
  localparam int unsigned BI_M1  = BI - 1;
  localparam int unsigned BO_M1  = BO - 1;
  localparam int unsigned YB_I   = Y / W;
  localparam int unsigned TB_I   = T / W;
  localparam logic [CW-1:0] LAST_IN  = BI_M1[CW-1:0];
  localparam logic [CW-1:0] LAST_OUT = BO_M1[CW-1:0];
  localparam logic [CW:0]   Y_BEATS  = YB_I[CW:0];
  localparam logic [CW:0]   T_BEATS  = TB_I[CW:0];

  state_t        state, state_nxt;
  logic [CW-1:0] beat, beat_nxt;
  logic          acc, out_acc, done_cap, clr;
  logic [Y-1:0]  data_q, data_sh;
  logic [T-1:0]  tag_q, tag_sh;
  logic          tag_lane_en;

  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == UNLOAD);
  assign core_start = (state == RUN);
  assign acc        = in_valid & in_ready;
  assign out_acc    = out_valid & out_ready;
  assign done_cap   = core_start & core_done;
  assign out_last   = out_valid && (beat == LAST_OUT);
  // Last unload beat leaving: wipe operands and results for the next message.
  assign clr        = out_acc && (beat == LAST_OUT);

  // State and shared beat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Next-state and beat-counter sequencing.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      LOAD: begin
        if (acc) begin
          if (beat == LAST_IN) begin
            state_nxt = RUN;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      RUN: begin
        if (core_done) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        if (out_acc) begin
          if (beat == LAST_OUT) begin
            state_nxt = LOAD;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = LOAD;
        beat_nxt  = '0;
      end
    endcase
  end

  ascon_lane_shreg #(.LF(K), .W(W), .CW(CW)) u_key (
    .clk(clk), .rst(rst), .clr(clr), .en(acc), .beat(beat), .lane(in_key), .q(key_o));
  ascon_lane_shreg #(.LF(N), .W(W), .CW(CW)) u_nonce (
    .clk(clk), .rst(rst), .clr(clr), .en(acc), .beat(beat), .lane(in_nonce), .q(nonce_o));
  ascon_lane_shreg #(.LF(L), .W(W), .CW(CW)) u_ad (
    .clk(clk), .rst(rst), .clr(clr), .en(acc), .beat(beat), .lane(in_ad), .q(ad_o));
  ascon_lane_shreg #(.LF(Y), .W(W), .CW(CW)) u_data (
    .clk(clk), .rst(rst), .clr(clr), .en(acc), .beat(beat), .lane(in_data), .q(data_o));

  // Capture core results on the done pulse; only honoured while running.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q <= '0;
      tag_q  <= '0;
    end else if (done_cap) begin
      data_q <= core_data_i;
      tag_q  <= core_tag_i;
    end
  end

`ifdef ASCON_DECRYPT_EN
  logic [T-1:0] exp_tag;

  ascon_lane_shreg #(.LF(T), .W(W), .CW(CW)) u_exp_tag (
    .clk(clk), .rst(rst), .clr(clr), .en(acc), .beat(beat), .lane(in_tag), .q(exp_tag));

  // Mode sampled on the first beat; tag comparison registered on done.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mode_o <= 1'b0;
      tag_ok <= 1'b0;
    end else begin
      if (acc && (beat == '0)) mode_o <= mode_i;
      if (done_cap)            tag_ok <= (core_tag_i == exp_tag);
    end
  end

  assign tag_lane_en = ~mode_o;
`else
  assign tag_lane_en = 1'b1;
`endif

  // MSB-first output lane selection; fields shorter than BO beats pad with zero.
  always_comb begin
    data_sh  = data_q << (int'(beat) * W);
    tag_sh   = tag_q << (int'(beat) * W);
    out_data = '0;
    out_tag  = '0;
    if (out_valid && ({1'b0, beat} < Y_BEATS)) out_data = data_sh[Y-1 -: W];
    if (out_valid && tag_lane_en && ({1'b0, beat} < T_BEATS)) out_tag = tag_sh[T-1 -: W];
  end

endmodule

// File: tb/tb_ascon_stream_io.sv
// Self-checking bench for ascon_stream_io (W=8 main instance, W=1 secondary instance).
// Expected output beats are queued when the core model responds and popped on handshake.
// Optional decrypt checks are compiled when ASCON_DECRYPT_EN is defined.
module tb_ascon_stream_io;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, core_done;
  logic [7:0]   in_key, in_nonce, in_ad, in_data;
  logic         in_ready, out_valid, out_last, core_start;
  logic [7:0]   out_data, out_tag;
  logic [127:0] key_o, nonce_o, core_tag_i;
  logic [31:0]  ad_o, data_o, core_data_i;

  logic         w1_in_valid, w1_out_ready, w1_core_done;
  logic         w1_in_key, w1_in_nonce, w1_in_ad, w1_in_data;
  logic         w1_in_ready, w1_out_valid, w1_out_last, w1_core_start;
  logic         w1_out_data, w1_out_tag;
  logic [127:0] w1_key_o, w1_nonce_o;
  logic [31:0]  w1_ad_o, w1_data_o;

`ifdef ASCON_DECRYPT_EN
  logic       mode_i, mode_o, tag_ok;
  logic [7:0] in_tag;
  logic       w1_mode_o, w1_tag_ok;
`endif

  ascon_stream_io #(.W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef ASCON_DECRYPT_EN
    .mode_i(mode_i), .in_tag(in_tag), .mode_o(mode_o), .tag_ok(tag_ok),
`endif
    .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_nonce(in_nonce), .in_ad(in_ad), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .data_o(data_o),
    .core_start(core_start), .core_done(core_done),
    .core_data_i(core_data_i), .core_tag_i(core_tag_i));

  ascon_stream_io #(.W(1)) w1 (
    .clk(clk), .rst(rst),
`ifdef ASCON_DECRYPT_EN
    .mode_i(1'b0), .in_tag(1'b0), .mode_o(w1_mode_o), .tag_ok(w1_tag_ok),
`endif
    .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_key(w1_in_key), .in_nonce(w1_in_nonce), .in_ad(w1_in_ad), .in_data(w1_in_data),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_data(w1_out_data),
    .out_tag(w1_out_tag), .out_last(w1_out_last), .key_o(w1_key_o), .nonce_o(w1_nonce_o),
    .ad_o(w1_ad_o), .data_o(w1_data_o), .core_start(w1_core_start), .core_done(w1_core_done),
    .core_data_i(32'h0), .core_tag_i(128'h0));

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] t;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [31:0]  AD    = 32'h30313233;
  localparam logic [31:0]  PT    = 32'h20212223;
  localparam logic [31:0]  CT    = 32'hDEADBEEF;
  localparam logic [127:0] TAG   = 128'h000102030405060708090A0B0C0D0E0F;

  task automatic test_reset(input string where);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_start !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ctrl: in_ready=%b out_valid=%b core_start=%b out_last=%b, need 1 0 0 0",
               where, in_ready, out_valid, core_start, out_last);
    end
    vectors++;
    if (key_o !== '0 || nonce_o !== '0 || ad_o !== '0 || data_o !== '0 ||
        out_data !== '0 || out_tag !== '0) begin
      miscompares++;
      $display("FAIL %s data: key=%h nonce=%h ad=%h data=%h od=%h ot=%h, need all zero",
               where, key_o, nonce_o, ad_o, data_o, out_data, out_tag);
    end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic do_load(input logic [31:0] ad, input logic [31:0] pt,
                         input logic mode, input logic [127:0] etag);
    for (int b = 0; b < 16; b++) begin
      in_valid = 1'b1;
      in_key   = 8'(KEY >> (8 * (15 - b)));
      in_nonce = 8'(NONCE >> (8 * (15 - b)));
      in_ad    = (b < 4) ? 8'(ad >> (8 * (3 - b))) : 8'($urandom);
      in_data  = (b < 4) ? 8'(pt >> (8 * (3 - b))) : 8'($urandom);
`ifdef ASCON_DECRYPT_EN
      mode_i   = (b == 0) ? mode : ~mode;
      in_tag   = 8'(etag >> (8 * (15 - b)));
`endif
      vectors++;
      if (in_ready !== 1'b1 || core_start !== 1'b0) begin
        miscompares++;
        $display("FAIL load_beat%0d: in_ready=%b core_start=%b, need 1 0", b, in_ready, core_start);
      end
      @(posedge clk); #1;
      if (b == 3) begin
        vectors++;
        if (ad_o !== ad || data_o !== pt) begin
          miscompares++;
          $display("FAIL load_full_b3: ad_o=%h data_o=%h, need %h %h", ad_o, data_o, ad, pt);
        end
      end
    end
    in_valid = 1'b0;
    in_key = 8'($urandom);
    in_ad  = 8'($urandom);
    vectors++;
    if (core_start !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_after_load: core_start=%b in_ready=%b, need 1 0", core_start, in_ready);
    end
    vectors++;
    if (key_o !== KEY || nonce_o !== NONCE || ad_o !== ad || data_o !== pt) begin
      miscompares++;
      $display("FAIL operands: key=%h nonce=%h ad=%h data=%h, need %h %h %h %h",
               key_o, nonce_o, ad_o, data_o, KEY, NONCE, ad, pt);
    end
  endtask

  task automatic core_respond(input logic [31:0] ct, input logic [127:0] tag, input logic dec);
    int budget = 0;
    while (core_start !== 1'b1 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    vectors++;
    if (core_start !== 1'b1) begin
      miscompares++;
      $display("FAIL core_start_wait: core_start=%b after %0d cycles, need 1", core_start, budget);
    end
    @(posedge clk); #1;
    core_data_i = ct;
    core_tag_i  = tag;
    core_done   = 1'b1;
    for (int b = 0; b < 16; b++) begin
      exp_t e;
      e.d    = (b < 4) ? 8'(ct >> (8 * (3 - b))) : 8'h00;
      e.t    = dec ? 8'h00 : 8'(tag >> (8 * (15 - b)));
      e.last = (b == 15);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    core_done   = 1'b0;
    core_data_i = $urandom;
    core_tag_i  = {$urandom, $urandom, $urandom, $urandom};
    vectors++;
    if (core_start !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL after_done: core_start=%b out_valid=%b, need 0 1", core_start, out_valid);
    end
  endtask

  // max_beats < 16 stops early (for the mid-unload reset scenario).
  task automatic do_unload(input int max_beats, input logic [3:0] pattern);
    int   got = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held_d = '0;
    logic [7:0] held_t = '0;
    while (got < max_beats && cyc < 200) begin
      out_ready = pattern[cyc % 4];
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b data=%h tag=%h, need 1 %h %h",
                   out_valid, out_data, out_tag, held_d, held_t);
        end
      end
      stalled = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unload_extra: beat data=%h with empty scoreboard, need none", out_data);
        end else begin
          exp_t e = sb.pop_front();
          if (out_data !== e.d || out_tag !== e.t || out_last !== e.last) begin
            miscompares++;
            $display("FAIL unload_beat%0d: data=%h tag=%h last=%b, need %h %h %b",
                     got, out_data, out_tag, out_last, e.d, e.t, e.last);
          end
        end
        got++;
      end else if (out_valid === 1'b1) begin
        stalled = 1'b1;
        held_d  = out_data;
        held_t  = out_tag;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    vectors++;
    if (got != max_beats) begin
      miscompares++;
      $display("FAIL unload_count: beats=%0d, need %0d", got, max_beats);
    end
    if (max_beats == 16) begin
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || key_o !== '0 || sb.size() != 0) begin
        miscompares++;
        $display("FAIL unload_done: in_ready=%b out_valid=%b key=%h left=%0d, need 1 0 0 0",
                 in_ready, out_valid, key_o, sb.size());
      end
    end
  endtask

  task automatic test_encrypt();
    do_load(AD, PT, 1'b0, '0);
    core_respond(CT, TAG, 1'b0);
    do_unload(16, 4'b1111);
  endtask

  task automatic test_stall();
    do_load(32'hA5A55A5A, 32'h0BADF00D, 1'b0, '0);
    core_respond(32'h12345678, ~TAG, 1'b0);
    do_unload(16, 4'b1001);
  endtask

  task automatic test_back_to_back();
    do_load(AD, PT, 1'b0, '0);
    core_respond(CT, TAG, 1'b0);
    do_unload(16, 4'b1111);
    do_load(32'h01020304, 32'hCAFEF00D, 1'b0, '0);
    core_respond(32'h55AA00FF, TAG, 1'b0);
    do_unload(16, 4'b1111);
  endtask

  task automatic test_reset_run_unload();
    do_load(AD, PT, 1'b0, '0);
    test_reset("rst_in_run");
    do_load(AD, PT, 1'b0, '0);
    core_respond(CT, TAG, 1'b0);
    do_unload(5, 4'b1111);
    test_reset("rst_mid_unload");
  endtask

  task automatic test_w1();
    for (int b = 0; b < 128; b++) begin
      w1_in_valid  = 1'b1;
      w1_in_key    = KEY[127 - b];
      w1_in_nonce  = NONCE[127 - b];
      w1_in_ad     = (b < 32) ? AD[31 - b] : 1'($urandom);
      w1_in_data   = (b < 32) ? PT[31 - b] : 1'($urandom);
      w1_core_done = (b == 50);
      if (b == 51) begin
        vectors++;
        if (w1_in_ready !== 1'b1 || w1_core_start !== 1'b0) begin
          miscompares++;
          $display("FAIL w1_spurious_done: in_ready=%b core_start=%b, need 1 0",
                   w1_in_ready, w1_core_start);
        end
      end
      if (b == 127) begin
        vectors++;
        if (w1_core_start !== 1'b0) begin
          miscompares++;
          $display("FAIL w1_early_start: core_start=%b, need 0", w1_core_start);
        end
      end
      @(posedge clk); #1;
    end
    w1_in_valid  = 1'b0;
    w1_core_done = 1'b0;
    vectors++;
    if (w1_core_start !== 1'b1 || w1_in_ready !== 1'b0 || w1_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL w1_start: core_start=%b in_ready=%b out_valid=%b, need 1 0 0",
               w1_core_start, w1_in_ready, w1_out_valid);
    end
    vectors++;
    if (w1_key_o !== KEY || w1_nonce_o !== NONCE || w1_ad_o !== AD || w1_data_o !== PT) begin
      miscompares++;
      $display("FAIL w1_operands: key=%h nonce=%h ad=%h data=%h, need %h %h %h %h",
               w1_key_o, w1_nonce_o, w1_ad_o, w1_data_o, KEY, NONCE, AD, PT);
    end
  endtask

`ifdef ASCON_DECRYPT_EN
  task automatic test_decrypt(input logic [127:0] core_tag, input logic want_ok);
    do_load(AD, CT, 1'b1, TAG);
    core_respond(PT, core_tag, 1'b1);
    vectors++;
    if (mode_o !== 1'b1 || tag_ok !== want_ok) begin
      miscompares++;
      $display("FAIL decrypt_tag: mode_o=%b tag_ok=%b, need 1 %b", mode_o, tag_ok, want_ok);
    end
    do_unload(16, 4'b1111);
    vectors++;
    if (tag_ok !== 1'b0 || mode_o !== 1'b0) begin
      miscompares++;
      $display("FAIL decrypt_clear: tag_ok=%b mode_o=%b, need 0 0", tag_ok, mode_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
    in_key = '0; in_nonce = '0; in_ad = '0; in_data = '0;
    core_data_i = '0; core_tag_i = '0;
    w1_in_valid = 1'b0; w1_out_ready = 1'b1; w1_core_done = 1'b0;
    w1_in_key = 1'b0; w1_in_nonce = 1'b0; w1_in_ad = 1'b0; w1_in_data = 1'b0;
`ifdef ASCON_DECRYPT_EN
    mode_i = 1'b0; in_tag = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset("reset_state");
    test_encrypt();
    test_stall();
    test_back_to_back();
    test_reset_run_unload();
    test_w1();
`ifdef ASCON_DECRYPT_EN
    test_decrypt(TAG, 1'b1);
    test_decrypt(128'h000102030405060708090A0B0C0D0E0E, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
